aurora_link_manager: RTL and testbench

//  Bring-up/recovery sequencer for the multi-lane Aurora receive wrapper. Drives the shared pma_init
//  and per-lane reset, watches per-lane channel_up/hard_error, retries failed lanes with a watchdog
//  and escalates to a global PMA re-init after repeated failures. Runs on the free-running init_clk.

---
 rtl/aurora_link_manager_pkg.sv | 38 +++
 rtl/aurora_link_manager_lane.sv | 129 ++++++++++++
 rtl/aurora_link_manager.sv | 137 +++++++++++++
 tb/tb_aurora_link_manager.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/aurora_link_manager_pkg.sv
// Shared definitions for the Aurora link manager.
// Contents:
//   g_state_e  - global sequencer states (PMA init, settle, run)
//   l_state_e  - per-lane supervisor states
//   PMA_CNT_W  - width of the global re-init counter
//   clog2()    - ceiling log2, at least 1, used to size the counters
package aurora_link_manager_pkg;

    typedef enum logic [1:0] {
        G_PMA    = 2'd0,
        G_SETTLE = 2'd1,
        G_RUN    = 2'd2
    } g_state_e;

    typedef enum logic [1:0] {
        L_IDLE  = 2'd0,
        L_RESET = 2'd1,
        L_WAIT  = 2'd2,
        L_UP    = 2'd3
    } l_state_e;

    localparam int PMA_CNT_W = 8;

    // Ceiling log2, never below 1 so that a counter always has at least one bit.
    // Counters with limit L are sized as clog2(L+1).
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/aurora_link_manager_lane.sv
// aurora_lane_supervisor: supervises one Aurora lane.
// Synchronises channel_up/hard_error, sequences the lane reset, runs the
// channel_up watchdog and counts consecutive failures.
// Ports:
//   clk, reset_n  - init_clk and asynchronous active-low reset
//   run           - global sequencer is (entering) the run phase
//   force_idle    - escalation: drop to idle and clear the retry count
//   enable        - lane is supervised
//   channel_up    - raw channel_up (user_clk domain)
//   hard_error    - raw hard_error (user_clk domain)
//   lane_reset    - registered Aurora reset for this lane, active high
//   link_ok       - registered, lane is in L_UP
//   retry_hit     - enabled lane has reached MAX_RETRY consecutive failures
module aurora_lane_supervisor
    import aurora_link_manager_pkg::*;
#(
    parameter int RST_CYCLES = 32,
    parameter int UP_TIMEOUT = 65536,
    parameter int MAX_RETRY  = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic run,
    input  logic force_idle,
    input  logic enable,
    input  logic channel_up,
    input  logic hard_error,
    output logic lane_reset,
    output logic link_ok,
    output logic retry_hit
);

    localparam int CNT_MAX = (RST_CYCLES > UP_TIMEOUT) ? RST_CYCLES : UP_TIMEOUT;
    localparam int CW      = clog2(CNT_MAX + 1);
    localparam int RW      = clog2(MAX_RETRY + 1);

    logic [1:0]    cu_sync_q;
    logic [1:0]    he_sync_q;
    l_state_e      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] retry_q, retry_d;
    logic          lane_reset_q, lane_reset_d;
    logic          link_ok_q, link_ok_d;
    logic          cu_s;
    logic          he_s;

    assign cu_s = cu_sync_q[1];
    assign he_s = he_sync_q[1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cu_sync_q    <= '0;
            he_sync_q    <= '0;
            state_q      <= L_IDLE;
            cnt_q        <= '0;
            retry_q      <= '0;
            lane_reset_q <= 1'b1;
            link_ok_q    <= 1'b0;
        end else begin
            cu_sync_q    <= {cu_sync_q[0], channel_up};
            he_sync_q    <= {he_sync_q[0], hard_error};
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            retry_q      <= retry_d;
            lane_reset_q <= lane_reset_d;
            link_ok_q    <= link_ok_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        // Escalation and disable override every lane transition.
        if (force_idle || !enable || !run) begin
            state_d = L_IDLE;
            cnt_d   = '0;
            retry_d = '0;
        end else begin
            unique case (state_q)
                L_IDLE: begin
                    state_d = L_RESET;
                    cnt_d   = '0;
                end
                L_RESET: begin
                    if (cnt_q == CW'(RST_CYCLES - 1)) begin
                        state_d = L_WAIT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                L_WAIT: begin
                    // hard_error is deliberately ignored here; only the watchdog decides.
                    if (cu_s) begin
                        state_d = L_UP;
                        cnt_d   = '0;
                        retry_d = '0;
                    end else if (cnt_q == CW'(UP_TIMEOUT - 1)) begin
                        state_d = L_RESET;
                        cnt_d   = '0;
                        retry_d = retry_q + 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                L_UP: begin
                    if (!cu_s || he_s) begin
                        state_d = L_RESET;
                        cnt_d   = '0;
                        retry_d = retry_q + 1'b1;
                    end
                end
                default: begin
                    state_d = L_IDLE;
                    cnt_d   = '0;
                    retry_d = '0;
                end
            endcase
        end
        lane_reset_d = (state_d == L_IDLE) || (state_d == L_RESET);
        link_ok_d    = (state_d == L_UP);
    end

    assign lane_reset = lane_reset_q;
    assign link_ok    = link_ok_q;
    assign retry_hit  = enable && (retry_q == RW'(MAX_RETRY));

endmodule

// File: rtl/aurora_link_manager.sv
// aurora_link_manager: bring-up/recovery sequencer for a multi-lane Aurora
// receive wrapper. Holds the global PMA-init/settle/run sequencer, the
// escalation OR across lanes, all_up and the re-init counter.
// Ports:
//   init_clk      - free-running clock
//   reset_n       - asynchronous active-low reset
//   enable_mask   - per-lane supervision enable
//   channel_up    - per-lane channel_up (user_clk domain)
//   hard_error    - per-lane hard_error (user_clk domain)
//   pma_init      - shared PMA init, registered
//   lane_reset    - per-lane Aurora reset, registered
//   link_ok       - per-lane "lane is up", registered
//   all_up        - all enabled lanes up (0 when none enabled), registered
//   pma_init_cnt  - global re-inits since reset, saturating
module aurora_link_manager
    import aurora_link_manager_pkg::*;
#(
    parameter int CNO           = 8,
    parameter int PMA_CYCLES    = 64,
    parameter int SETTLE_CYCLES = 256,
    parameter int RST_CYCLES    = 32,
    parameter int UP_TIMEOUT    = 65536,
    parameter int MAX_RETRY     = 4
) (
    input  logic                 init_clk,
    input  logic                 reset_n,
    input  logic [CNO-1:0]       enable_mask,
    input  logic [CNO-1:0]       channel_up,
    input  logic [CNO-1:0]       hard_error,
    output logic                 pma_init,
    output logic [CNO-1:0]       lane_reset,
    output logic [CNO-1:0]       link_ok,
    output logic                 all_up,
    output logic [PMA_CNT_W-1:0] pma_init_cnt
);

    localparam int G_MAX = (PMA_CYCLES > SETTLE_CYCLES) ? PMA_CYCLES : SETTLE_CYCLES;
    localparam int GW    = clog2(G_MAX + 1);

    g_state_e             g_state_q, g_state_d;
    logic [GW-1:0]        g_cnt_q, g_cnt_d;
    logic                 pma_init_q, pma_init_d;
    logic                 all_up_q, all_up_d;
    logic [PMA_CNT_W-1:0] pma_cnt_q, pma_cnt_d;
    logic [CNO-1:0]       retry_hit;
    logic                 escalate;
    logic                 run;

    // Several lanes hitting the limit together still count as one escalation.
    assign escalate = |retry_hit;

    always_ff @(posedge init_clk or negedge reset_n) begin
        if (!reset_n) begin
            g_state_q  <= G_PMA;
            g_cnt_q    <= '0;
            pma_init_q <= 1'b1;
            all_up_q   <= 1'b0;
            pma_cnt_q  <= '0;
        end else begin
            g_state_q  <= g_state_d;
            g_cnt_q    <= g_cnt_d;
            pma_init_q <= pma_init_d;
            all_up_q   <= all_up_d;
            pma_cnt_q  <= pma_cnt_d;
        end
    end

    always_comb begin
        g_state_d = g_state_q;
        g_cnt_d   = g_cnt_q;
        pma_cnt_d = pma_cnt_q;
        if (escalate) begin
            g_state_d = G_PMA;
            g_cnt_d   = '0;
            if (pma_cnt_q != '1) begin
                pma_cnt_d = pma_cnt_q + 1'b1;
            end
        end else begin
            unique case (g_state_q)
                G_PMA: begin
                    if (g_cnt_q == GW'(PMA_CYCLES - 1)) begin
                        g_state_d = G_SETTLE;
                        g_cnt_d   = '0;
                    end else begin
                        g_cnt_d = g_cnt_q + 1'b1;
                    end
                end
                G_SETTLE: begin
                    if (g_cnt_q == GW'(SETTLE_CYCLES - 1)) begin
                        g_state_d = G_RUN;
                        g_cnt_d   = '0;
                    end else begin
                        g_cnt_d = g_cnt_q + 1'b1;
                    end
                end
                G_RUN: begin
                    g_cnt_d = '0;
                end
                default: begin
                    g_state_d = G_PMA;
                    g_cnt_d   = '0;
                end
            endcase
        end
        pma_init_d = (g_state_d == G_PMA);
        // Disabled lanes are don't-care; an empty mask means nothing is up.
        all_up_d   = (|enable_mask) && (&(link_ok | ~enable_mask));
    end

    // Lanes see the run phase on the same edge the global FSM enters it, so the
    // lane reset window starts right at the end of the settle period.
    assign run = (g_state_d == G_RUN);

    for (genvar gi = 0; gi < CNO; gi++) begin : g_lane
        aurora_lane_supervisor #(
            .RST_CYCLES (RST_CYCLES),
            .UP_TIMEOUT (UP_TIMEOUT),
            .MAX_RETRY  (MAX_RETRY)
        ) u_lane (
            .clk        (init_clk),
            .reset_n    (reset_n),
            .run        (run),
            .force_idle (escalate),
            .enable     (enable_mask[gi]),
            .channel_up (channel_up[gi]),
            .hard_error (hard_error[gi]),
            .lane_reset (lane_reset[gi]),
            .link_ok    (link_ok[gi]),
            .retry_hit  (retry_hit[gi])
        );
    end

    assign pma_init     = pma_init_q;
    assign all_up       = all_up_q;
    assign pma_init_cnt = pma_cnt_q;

endmodule

// File: tb/tb_aurora_link_manager.sv
// Directed bench for aurora_link_manager with small parameters
// (PMA=4, SETTLE=8, RST=4, UP_TIMEOUT=32, MAX_RETRY=2, CNO=4).
// Cycle n = state after the n-th rising edge following reset release;
// everything is driven and sampled on the falling edge.
module tb_aurora_link_manager;

    localparam int CNO = 4;

    logic           init_clk;
    logic           reset_n;
    logic [CNO-1:0] enable_mask;
    logic [CNO-1:0] channel_up;
    logic [CNO-1:0] hard_error;
    logic           pma_init;
    logic [CNO-1:0] lane_reset;
    logic [CNO-1:0] link_ok;
    logic           all_up;
    logic [7:0]     pma_init_cnt;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    aurora_link_manager #(
        .CNO           (CNO),
        .PMA_CYCLES    (4),
        .SETTLE_CYCLES (8),
        .RST_CYCLES    (4),
        .UP_TIMEOUT    (32),
        .MAX_RETRY     (2)
    ) dut (
        .init_clk     (init_clk),
        .reset_n      (reset_n),
        .enable_mask  (enable_mask),
        .channel_up   (channel_up),
        .hard_error   (hard_error),
        .pma_init     (pma_init),
        .lane_reset   (lane_reset),
        .link_ok      (link_ok),
        .all_up       (all_up),
        .pma_init_cnt (pma_init_cnt)
    );

    initial init_clk = 1'b0;
    always #5 init_clk = ~init_clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h cyc=%0d", tag, act, exp, cyc);
        end else begin
            $display("ok   %s: got=%0h cyc=%0d", tag, act, cyc);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge init_clk);
            cyc++;
        end
    endtask

    task automatic go_to(input int k);
        tick(k - cyc);
    endtask

    // Hold reset for two cycles, release on a falling edge, restart cycle count.
    task automatic do_reset();
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
        cyc = 0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pma"},   pma_init,     1);
        chk({tag, "_lrst"},  lane_reset,   4'hF);
        chk({tag, "_lok"},   link_ok,      0);
        chk({tag, "_allup"}, all_up,       0);
        chk({tag, "_cnt"},   pma_init_cnt, 0);
    endtask

    initial begin
        reset_n     = 1'b0;
        enable_mask = 4'hF;
        channel_up  = 4'hF;
        hard_error  = 4'h0;

        // 1: basic bring-up, channel_up tied high
        tick(2);
        chk_reset_vals("rst");
        reset_n = 1'b1;
        cyc = 0;
        go_to(3);  chk("t1_pma_c3",   pma_init, 1);
        go_to(4);  chk("t1_pma_c4",   pma_init, 0);
        go_to(15); chk("t1_lrst_c15", lane_reset, 4'hF);
        go_to(16); chk("t1_lrst_c16", lane_reset, 4'h0);
        chk("t1_lok_c16", link_ok, 0);
        go_to(18); chk("t1_lok_c18",   link_ok, 4'hF);
        go_to(19); chk("t1_allup_c19", all_up, 1);

        // 2: lane 2 never comes up -> two timeouts -> escalation
        channel_up = 4'b1011;
        do_reset();
        go_to(47); chk("t2_lrst_c47", lane_reset, 4'h0);
        go_to(48); chk("t2_lrst_c48", lane_reset, 4'b0100);
        chk("t2_allup_c48", all_up, 0);
        go_to(51); chk("t2_lrst_c51", lane_reset, 4'b0100);
        go_to(52); chk("t2_lrst_c52", lane_reset, 4'h0);
        go_to(84); chk("t2_lrst_c84", lane_reset, 4'b0100);
        chk("t2_pma_c84", pma_init, 0);
        chk("t2_lok_c84", link_ok, 4'b1011);
        chk("t2_cnt_c84", pma_init_cnt, 0);
        go_to(85); chk("t2_pma_c85", pma_init, 1);
        chk("t2_cnt_c85",  pma_init_cnt, 1);
        chk("t2_lrst_c85", lane_reset, 4'hF);
        chk("t2_lok_c85",  link_ok, 0);
        go_to(88); chk("t2_pma_c88", pma_init, 1);
        go_to(89); chk("t2_pma_c89", pma_init, 0);

        // 3: single-cycle hard_error on lane 1 while up
        channel_up = 4'hF;
        do_reset();
        go_to(20); chk("t3_lok_c20", link_ok, 4'hF);
        hard_error = 4'b0010;
        tick(1);
        hard_error = 4'b0000;
        go_to(22); chk("t3_lrst_c22", lane_reset, 4'h0);
        go_to(23); chk("t3_lrst_c23", lane_reset, 4'b0010);
        chk("t3_lok_c23", link_ok, 4'b1101);
        go_to(24); chk("t3_allup_c24", all_up, 0);
        go_to(26); chk("t3_lrst_c26", lane_reset, 4'b0010);
        chk("t3_lok_c26", link_ok, 4'b1101);
        go_to(27); chk("t3_lrst_c27", lane_reset, 4'h0);
        go_to(28); chk("t3_lok_c28", link_ok, 4'hF);
        chk("t3_cnt_c28", pma_init_cnt, 0);

        // 4: partial mask, then empty mask
        enable_mask = 4'b0101;
        do_reset();
        go_to(16); chk("t4_lrst_c16", lane_reset, 4'b1010);
        go_to(19); chk("t4_lok_c19",  link_ok, 4'b0101);
        chk("t4_allup_c19", all_up, 1);
        go_to(30); chk("t4_lrst_c30", lane_reset, 4'b1010);
        enable_mask = 4'b0000;
        tick(2);
        chk("t4_allup_mask0", all_up, 0);
        chk("t4_lok_mask0",   link_ok, 0);
        chk("t4_lrst_mask0",  lane_reset, 4'hF);
        enable_mask = 4'hF;

        // 5: lanes 0 and 3 fail in lockstep -> one increment per escalation
        channel_up = 4'b0110;
        do_reset();
        go_to(84);  chk("t5_cnt_c84",  pma_init_cnt, 0);
        go_to(85);  chk("t5_cnt_c85",  pma_init_cnt, 1);
        chk("t5_lrst_c85", lane_reset, 4'hF);
        go_to(169); chk("t5_cnt_c169", pma_init_cnt, 1);
        go_to(170); chk("t5_cnt_c170", pma_init_cnt, 2);
        chk("t5_pma_c170", pma_init, 1);

        // 6: reset_n pulsed during G_SETTLE, then during L_WAIT
        go_to(178);
        chk("t6_pma_settle", pma_init, 0);
        reset_n = 1'b0;
        #1;
        chk_reset_vals("t6a");
        channel_up = 4'h0;
        tick(1);
        reset_n = 1'b1;
        cyc = 0;
        go_to(3);  chk("t6a_pma_c3", pma_init, 1);
        go_to(4);  chk("t6a_pma_c4", pma_init, 0);
        go_to(20); chk("t6b_lrst_wait", lane_reset, 4'h0);
        reset_n = 1'b0;
        #1;
        chk_reset_vals("t6b");
        tick(1);
        reset_n = 1'b1;
        cyc = 0;
        go_to(15); chk("t6b_lrst_c15", lane_reset, 4'hF);
        go_to(16); chk("t6b_lrst_c16", lane_reset, 4'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
